jk_latch_driver: RTL and testbench

//  Synchronous write-side controller for a bank of asynchronous NAND-based JK latches (j, k in; q, qbar out).

---
 rtl/jk_latch_driver.sv | 135 +++++++++++++
 tb/tb_jk_latch_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_latch_driver.sv
// Write-side controller for a bank of unclocked NAND JK latches: pulses J/K toward a target word,
// releases to hold, lets the bank settle, then reads it back through a synchroniser and retries on mismatch.
module jk_latch_driver #(
  parameter int WIDTH      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 4,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             err
);

  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] CHECK   = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    retry_cnt;
  logic             retry_pend;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] q_meta;
  logic [WIDTH-1:0] q_s;

  // J only where a 0 must become 1, K only where a 1 must become 0, so J&K is never 1 on a bit.
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] cur);
    return tgt & ~cur;
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] cur);
    return ~tgt & cur;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta <= '0;
      q_s    <= '0;
    end else begin
      q_meta <= q_fb;
      q_s    <= q_meta;
    end
  end

  assign in_ready = (state == IDLE);

  // The readback verdict is registered on the edge that leaves RELEASE, so done lines up with
  // entry to CHECK; a pending retry reloads J/K from fresh feedback on the edge that leaves CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      target     <= '0;
      j          <= '0;
      k          <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            target     <= in_target;
            j          <= excite_j(in_target, q_s);
            k          <= excite_k(in_target, q_s);
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            cnt        <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == PULSE_LAST) begin
            j     <= '0;
            k     <= '0;
            cnt   <= '0;
            state <= RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= CHECK;
            if (q_s == target) begin
              done <= 1'b1;
            end else if (retry_cnt < RETRY_LIMIT) begin
              retry_pend <= 1'b1;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt <= '0;
          if (retry_pend) begin
            retry_pend <= 1'b0;
            retry_cnt  <= retry_cnt + RW'(1);
            j          <= excite_j(target, q_s);
            k          <= excite_k(target, q_s);
            state      <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_latch_driver.sv
// Directed bench for jk_latch_driver: a behavioural JK latch bank closes the loop, with an
// optional stuck-at-0 mask on the feedback to provoke retries.
module tb_jk_latch_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_target = '0;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q_fb;
  logic       done;
  logic       err;

  logic [3:0] q_bank = '0;
  logic [3:0] load_val = '0;
  logic       load_bank = 1'b0;
  logic [3:0] stuck_low = '0;
  logic       overlap_seen = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  jk_latch_driver dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Latch bank model: J sets, K clears, neither holds; a preset overrides for scenario setup.
  always @(negedge clk) begin
    if (load_bank) begin
      q_bank <= load_val;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (j[i]) q_bank[i] <= 1'b1;
        else if (k[i]) q_bank[i] <= 1'b0;
      end
    end
  end

  assign q_fb = q_bank & ~stuck_low;

  always @(negedge clk) begin
    if ((j & k) != 4'b0000) overlap_seen = 1'b1;
  end

  task automatic set_bank(input logic [3:0] val);
    @(negedge clk); #1;
    load_val  = val;
    load_bank = 1'b1;
    @(negedge clk); #1;
    load_bank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic start_op(input logic [3:0] tgt, input logic hold);
    @(negedge clk);
    in_valid  = 1'b1;
    in_target = tgt;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done(input int first, input int last, output int at, output logic e);
    at = -1;
    e  = 1'b0;
    for (int n = first; n <= last; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        at = n;
        e  = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int at;
    logic e;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({j, k, done, err, in_ready} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: j=%b k=%b done=%b err=%b rdy=%b, want 0000 0000 0 0 1",
               j, k, done, err, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    set_bank(4'b0000);
    start_op(4'b0101, 1'b0);
    @(posedge clk); #1;
    vectors++;
    if (j !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL reset_predrive_j: j=%b, want 0101", j);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({j, k, done, in_ready} !== {4'b0, 4'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_middrive: j=%b k=%b done=%b rdy=%b, want 0000 0000 0 1",
               j, k, done, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_done(1, 10, at, e);
    vectors++;
    if (at != -1) begin
      miscompares++;
      $display("[TB] FAIL reset_no_done: done seen at edge %0d, want none", at);
    end
  endtask

  task automatic test_set_from_zero;
    int at;
    logic e;
    set_bank(4'b0000);
    start_op(4'b1010, 1'b0);
    vectors++;
    if ({j, k, in_ready} !== {4'b1010, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL set_e0: j=%b k=%b rdy=%b, want 1010 0000 0", j, k, in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if ({j, k} !== {4'b1010, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL set_e1: j=%b k=%b, want 1010 0000", j, k);
    end
    @(posedge clk); #1;
    vectors++;
    if ({j, k} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL set_e2_release: j=%b k=%b, want 0000 0000", j, k);
    end
    wait_done(3, 12, at, e);
    vectors++;
    if (at != 6 || e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL set_done: edge=%0d err=%b, want edge 6 err 0", at, e);
    end
    vectors++;
    if (q_bank !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL set_bank: q=%b, want 1010", q_bank);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done, err} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL set_done_width: done=%b err=%b, want 0 0", done, err);
    end
  endtask

  task automatic test_mixed;
    int at;
    logic e;
    set_bank(4'b1100);
    start_op(4'b0110, 1'b0);
    vectors++;
    if ({j, k} !== {4'b0010, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL mixed_jk: j=%b k=%b, want 0010 1000", j, k);
    end
    wait_done(1, 12, at, e);
    vectors++;
    if (at != 6 || e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mixed_done: edge=%0d err=%b, want edge 6 err 0", at, e);
    end
    vectors++;
    if (q_bank !== 4'b0110) begin
      miscompares++;
      $display("[TB] FAIL mixed_bank: q=%b, want 0110", q_bank);
    end
  endtask

  task automatic test_noop;
    int at;
    logic e;
    logic nz;
    set_bank(4'b0011);
    start_op(4'b0011, 1'b0);
    at = -1;
    e  = 1'b0;
    nz = ((j | k) != 4'b0000);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if ((j | k) != 4'b0000) nz = 1'b1;
      if (done === 1'b1) begin
        at = n;
        e  = err;
        break;
      end
    end
    vectors++;
    if (nz !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL noop_jk: nonzero j/k seen=%b, want 0", nz);
    end
    vectors++;
    if (at != 6 || e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL noop_done: edge=%0d err=%b, want edge 6 err 0", at, e);
    end
  endtask

  task automatic test_stuck;
    int at;
    logic e;
    stuck_low = 4'b0001;
    set_bank(4'b0000);
    start_op(4'b0001, 1'b0);
    vectors++;
    if ({j, k} !== {4'b0001, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL stuck_jk: j=%b k=%b, want 0001 0000", j, k);
    end
    wait_done(1, 30, at, e);
    vectors++;
    if (at != 20 || e !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stuck_done: edge=%0d err=%b, want edge 20 err 1", at, e);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done, err} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL stuck_err_width: done=%b err=%b, want 0 0", done, err);
    end
    stuck_low = 4'b0000;
  endtask

  task automatic test_back_to_back;
    int at;
    logic e;
    set_bank(4'b0000);
    start_op(4'b0101, 1'b1);
    in_target = 4'b1111;
    wait_done(1, 12, at, e);
    vectors++;
    if (at != 6 || e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_first_done: edge=%0d err=%b, want edge 6 err 0", at, e);
    end
    vectors++;
    if (q_bank !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL busy_first_bank: q=%b, want 0101", q_bank);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_idle_ready: rdy=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if ({j, k, in_ready} !== {4'b1010, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL busy_second_accept: j=%b k=%b rdy=%b, want 1010 0000 0", j, k, in_ready);
    end
    wait_done(1, 12, at, e);
    vectors++;
    if (at != 6 || e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_second_done: edge=%0d err=%b, want edge 6 err 0", at, e);
    end
    vectors++;
    if (q_bank !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL busy_second_bank: q=%b, want 1111", q_bank);
    end
  endtask

  initial begin
    test_reset;
    test_set_from_zero;
    test_mixed;
    test_noop;
    test_stuck;
    test_back_to_back;
    vectors++;
    if (overlap_seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL jk_overlap: j&k nonzero seen=%b, want 0", overlap_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
